// File: rtl/ff_bank_pkg.sv
// Shared definitions for the configurable flip-flop bank: mode encoding
// and the supported width range.
package ff_bank_pkg;

    // Widest bank the carry chain and parameter checks are sized for.
    localparam int MAX_WIDTH = 32;

    // Operating mode of every bit in the bank; 3'b111 is reserved and
    // behaves exactly like HOLD.
    typedef enum logic [2:0] {
        MODE_HOLD   = 3'b000,
        MODE_D      = 3'b001,
        MODE_T      = 3'b010,
        MODE_JK     = 3'b011,
        MODE_SR     = 3'b100,
        MODE_CNT_UP = 3'b101,
        MODE_CNT_DN = 3'b110,
        MODE_RSVD   = 3'b111
    } mode_e;

endpackage

// File: rtl/ff_bank_cell.sv
// Single-bit next-state logic. Holds no state; the bank owns the register.
// In counter modes carry_in says whether this bit toggles on this edge.
module ff_cell
    import ff_bank_pkg::*;
(
    input  mode_e mode,
    input  logic  q,
    input  logic  a,
    input  logic  b,
    input  logic  carry_in,
    output logic  next_q
);

    // Per-bit next-state selection for every mode.
    always_comb begin
        // NOTE: default first so every path assigns next_q and no latch is inferred.
        next_q = q;
        unique case (mode)
            MODE_D:      next_q = a;
            MODE_T:      next_q = q ^ a;
            MODE_JK: begin
                unique case ({a, b})
                    2'b00:   next_q = q;
                    2'b01:   next_q = 1'b0;
                    2'b10:   next_q = 1'b1;
                    default: next_q = ~q;
                endcase
            end
            MODE_SR: begin
                // S=R=1 is illegal: keep the bit, the bank raises invalid.
                unique case ({a, b})
                    2'b01:   next_q = 1'b0;
                    2'b10:   next_q = 1'b1;
                    default: next_q = q;
                endcase
            end
            MODE_CNT_UP,
            MODE_CNT_DN: next_q = q ^ carry_in;
            default:     next_q = q;   // HOLD and reserved
        endcase
    end

endmodule

// File: rtl/ff_bank.sv
// Bank of WIDTH flip-flops whose per-bit behaviour (D, T, JK, SR or
// up/down counter) is selected by mode on every edge. Owns the state
// register, the counter carry chain and the invalid/wrap flags.
module ff_bank
    import ff_bank_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic             invalid,
    output logic             wrap
);

    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("ff_bank: WIDTH must be in 1..%0d", MAX_WIDTH);
    end

    mode_e            mode_s;
    logic [WIDTH-1:0] carry;      // toggle enable seen by each bit
    logic             carry_out;  // every bit toggles: counter wraps
    logic [WIDTH-1:0] q_next;
    logic             sr_illegal;
    logic             wrap_next;

    assign mode_s = mode_e'(mode);
    assign Qn     = ~Q;

    // Ripple the counter carry: up counts need all lower bits 1,
    // down counts need all lower bits 0; bit 0 always toggles.
    always_comb begin
        logic run;
        run   = 1'b1;
        carry = '0;
        for (int i = 0; i < WIDTH; i++) begin
            carry[i] = run;
            run      = run & ((mode_s == MODE_CNT_DN) ? ~Q[i] : Q[i]);
        end
        carry_out = run;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        ff_cell u_cell (
            .mode     (mode_s),
            .q        (Q[i]),
            .a        (a[i]),
            .b        (b[i]),
            .carry_in (carry[i]),
            .next_q   (q_next[i])
        );
    end

    assign sr_illegal = (mode_s == MODE_SR) && (|(a & b));
    assign wrap_next  = ((mode_s == MODE_CNT_UP) || (mode_s == MODE_CNT_DN)) && carry_out;

    // State register and one-cycle flag pulses; reset wins over everything.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so all registers update from pre-edge values.
        if (reset) begin
            Q       <= INIT;
            invalid <= 1'b0;
            wrap    <= 1'b0;
        end else if (en) begin
            Q       <= q_next;
            invalid <= sr_illegal;
            wrap    <= wrap_next;
        end else begin
            invalid <= 1'b0;
            wrap    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ff_bank.sv
// Directed bench for ff_bank: a vector table run on a WIDTH=4, INIT=0
// instance, then hand sequences for reset behaviour using a second
// instance with INIT=4'b1010 driven by the same inputs.
module tb_ff_bank;

    localparam int         W     = 4;
    localparam logic [3:0] INIT1 = 4'b1010;

    localparam logic [2:0] HOLD = 3'b000, DM = 3'b001, TM = 3'b010, JK = 3'b011,
                           SR = 3'b100, UP = 3'b101, DN = 3'b110, RSV = 3'b111;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         en = 1'b0;
    logic [2:0]   mode = HOLD;
    logic [W-1:0] a = '0, b = '0;
    logic [W-1:0] q0, qn0, q1, qn1;
    logic         inv0, wrap0, inv1, wrap1;

    int applied = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    ff_bank #(.WIDTH(W), .INIT(4'b0000)) dut0 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .a(a), .b(b),
        .Q(q0), .Qn(qn0), .invalid(inv0), .wrap(wrap0)
    );

    ff_bank #(.WIDTH(W), .INIT(INIT1)) dut1 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .a(a), .b(b),
        .Q(q1), .Qn(qn1), .invalid(inv1), .wrap(wrap1)
    );

    typedef struct {
        logic         rst;
        logic         en;
        logic [2:0]   mode;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_q;
        logic         exp_inv;
        logic         exp_wrap;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs away from the edge, then sample 1 time unit after it.
    task automatic step(input logic r, input logic e, input logic [2:0] m,
                        input logic [W-1:0] va, input logic [W-1:0] vb);
        @(negedge clk);
        reset = r; en = e; mode = m; a = va; b = vb;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];

    initial begin
        //          rst  en  mode  a        b        Q        inv   wrap
        vecs.push_back('{1'b1, 1'b0, TM,  4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, TM,  4'b0101, 4'b0000, 4'b0101, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, TM,  4'b0101, 4'b0000, 4'b0000, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, TM,  4'b0101, 4'b0000, 4'b0101, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, DM,  4'b1110, 4'b1111, 4'b1110, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, UP,  4'b0101, 4'b1010, 4'b1111, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, UP,  4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b1, UP,  4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, DN,  4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, DN,  4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, DN,  4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, DN,  4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, DM,  4'b0011, 4'b0000, 4'b0011, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, JK,  4'b1010, 4'b0110, 4'b1001, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, DM,  4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, SR,  4'b1001, 4'b0001, 4'b1000, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, HOLD,4'b1111, 4'b0000, 4'b1000, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, RSV, 4'b0111, 4'b0101, 4'b1000, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, SR,  4'b0000, 4'b1000, 4'b0000, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, SR,  4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, SR,  4'b0011, 4'b0011, 4'b0000, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, DN,  4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, SR,  4'b0001, 4'b0001, 4'b0000, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, SR,  4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, DM,  4'b1100, 4'b0000, 4'b1100, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, TM,  4'b0110, 4'b1111, 4'b1010, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, JK,  4'b0000, 4'b0000, 4'b1010, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, JK,  4'b1111, 4'b1111, 4'b0101, 1'b0, 1'b0});

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].a, vecs[i].b);
            check($sformatf("v%0d Q", i),       {28'b0, q0},    {28'b0, vecs[i].exp_q});
            check($sformatf("v%0d Qn", i),      {28'b0, qn0},   {28'b0, ~vecs[i].exp_q});
            check($sformatf("v%0d invalid", i), {31'b0, inv0},  {31'b0, vecs[i].exp_inv});
            check($sformatf("v%0d wrap", i),    {31'b0, wrap0}, {31'b0, vecs[i].exp_wrap});
        end

        // Non-zero INIT appears on Q and Qn in the cycle after reset.
        step(1'b1, 1'b0, HOLD, 4'b0000, 4'b0000);
        check("init1 Q",  {28'b0, q1},  {28'b0, INIT1});
        check("init1 Qn", {28'b0, qn1}, {28'b0, ~INIT1});
        check("init0 Q",  {28'b0, q0},  32'h0);

        // Reset mid-count at 0111 with en=1 abandons the count.
        step(1'b0, 1'b1, DM, 4'b0111, 4'b0000);
        check("load1 Q", {28'b0, q1}, 32'h7);
        step(1'b1, 1'b1, UP, 4'b1111, 4'b1111);
        check("midrst Q",       {28'b0, q1},   {28'b0, INIT1});
        check("midrst wrap",    {31'b0, wrap1}, 32'h0);
        check("midrst invalid", {31'b0, inv1},  32'h0);

        // Reset on the edge that would have wrapped suppresses the wrap pulse.
        step(1'b0, 1'b1, DM, 4'b1111, 4'b0000);
        check("load0 Q", {28'b0, q0}, 32'hF);
        step(1'b1, 1'b1, UP, 4'b0000, 4'b0000);
        check("wraprst Q0",   {28'b0, q0},    32'h0);
        check("wraprst wrap0",{31'b0, wrap0}, 32'h0);
        check("wraprst Q1",   {28'b0, q1},    {28'b0, INIT1});

        // Down count from INIT1 after release, then wrap pulse lasts one cycle.
        step(1'b0, 1'b1, DN, 4'b0000, 4'b0000);
        check("dn1 Q1", {28'b0, q1}, 32'h9);
        check("dn1 Q0", {28'b0, q0}, 32'hF);
        check("dn1 wrap0", {31'b0, wrap0}, 32'h1);
        step(1'b0, 1'b1, HOLD, 4'b0000, 4'b0000);
        check("hold wrap0", {31'b0, wrap0}, 32'h0);
        check("hold Q1", {28'b0, q1}, 32'h9);

        $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
        $finish;
    end

endmodule
